// File: rtl/morse_pkg.sv
// Shared Morse symbol codes and classifier FSM state encoding.
package morse_pkg;

  localparam logic [1:0] SYM_DOT  = 2'd0;
  localparam logic [1:0] SYM_DASH = 2'd1;
  localparam logic [1:0] SYM_CHAR = 2'd2;
  localparam logic [1:0] SYM_WORD = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/key_debounce.sv
// Raw key synchroniser, polarity fold and debouncer producing a clean pressed level.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic key_down
);

  localparam int unsigned CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic        RAW_RELEASED = (ACTIVE_LOW != 0);

  logic             sync_q1;
  logic             sync_q2;
  logic             sample_c;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= RAW_RELEASED;
      sync_q2 <= RAW_RELEASED;
    end else begin
      sync_q1 <= button;
      sync_q2 <= sync_q1;
    end
  end

  assign sample_c = RAW_RELEASED ? ~sync_q2 : sync_q2;

  // Any sample agreeing with the current level restarts the stability count.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_down <= 1'b0;
      cnt      <= '0;
    end else if (sample_c == key_down) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      key_down <= sample_c;
      cnt      <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/morse_key_timer.sv
// Morse key timing classifier: debounced key, tick timer and dot/dash/gap FSM.
module morse_key_timer
  import morse_pkg::*;
#(
  parameter int unsigned TICK_CYCLES     = 50_000_000,
  parameter int unsigned T_W             = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned DOT_MAX         = 1,
  parameter int unsigned CANCEL_MIN      = 7,
  parameter int unsigned CHAR_GAP_MIN    = 3,
  parameter int unsigned WORD_GAP_MIN    = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           button,
  output logic           sym_valid,
  output logic [1:0]     sym_code,
  output logic           cancel,
  output logic [T_W-1:0] press_ticks,
  output logic           key_down,
  output logic [T_W-1:0] t
);

  localparam int unsigned CYC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [CYC_W-1:0] cyc;
  logic             tick_c;
  logic             t_step_c;
  logic [T_W-1:0]   t_inc_c;
  logic             sym_valid_nxt;
  logic [1:0]       sym_code_nxt;
  logic             cancel_nxt;
  logic [T_W-1:0]   press_ticks_nxt;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (ACTIVE_LOW)
  ) u_key_debounce (
    .clk      (clk),
    .reset    (reset),
    .button   (button),
    .key_down (key_down)
  );

  // t_inc_c includes the current cycle, so a press of N cycles measures floor(N/TICK_CYCLES).
  assign tick_c   = (cyc == CYC_W'(TICK_CYCLES - 1));
  assign t_step_c = tick_c && (t != {T_W{1'b1}});
  assign t_inc_c  = t_step_c ? t + T_W'(1) : t;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    sym_valid_nxt   = 1'b0;
    sym_code_nxt    = sym_code;
    cancel_nxt      = 1'b0;
    press_ticks_nxt = press_ticks;
    case (state)
      IDLE: begin
        if (key_down) state_nxt = PRESS;
      end
      PRESS: begin
        if (!key_down) begin
          state_nxt       = GAP;
          press_ticks_nxt = t_inc_c;
          if (t_inc_c <= T_W'(DOT_MAX)) begin
            sym_valid_nxt = 1'b1;
            sym_code_nxt  = SYM_DOT;
          end else if (t_inc_c < T_W'(CANCEL_MIN)) begin
            sym_valid_nxt = 1'b1;
            sym_code_nxt  = SYM_DASH;
          end else begin
            cancel_nxt = 1'b1;
          end
        end
      end
      GAP: begin
        // A new press wins; thresholds fire only on the tick that reaches them.
        if (key_down) begin
          state_nxt = PRESS;
        end else if (t_step_c && (t_inc_c == T_W'(WORD_GAP_MIN))) begin
          state_nxt     = IDLE;
          sym_valid_nxt = 1'b1;
          sym_code_nxt  = SYM_WORD;
        end else if (t_step_c && (t_inc_c == T_W'(CHAR_GAP_MIN))) begin
          sym_valid_nxt = 1'b1;
          sym_code_nxt  = SYM_CHAR;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Tick timer restarts on every state change.
  always_ff @(posedge clk) begin
    if (reset || (state_nxt != state)) begin
      cyc <= '0;
      t   <= '0;
    end else if (tick_c) begin
      cyc <= '0;
      t   <= t_inc_c;
    end else begin
      cyc <= cyc + CYC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sym_valid   <= 1'b0;
      sym_code    <= 2'd0;
      cancel      <= 1'b0;
      press_ticks <= '0;
    end else begin
      sym_valid   <= sym_valid_nxt;
      sym_code    <= sym_code_nxt;
      cancel      <= cancel_nxt;
      press_ticks <= press_ticks_nxt;
    end
  end

endmodule

// File: tb/tb_morse_key_timer.sv
// Scoreboard bench for morse_key_timer with a duration-based reference model.
module tb_morse_key_timer;

  localparam int unsigned TICK = 10;
  localparam int unsigned DEB  = 3;
  localparam int unsigned T_W  = 4;
  localparam int          TMAX = 15;
  localparam logic        PRESSED  = 1'b0;
  localparam logic        RELEASED = 1'b1;

  logic           clk = 1'b0;
  logic           reset;
  logic           button;
  logic           sym_valid;
  logic [1:0]     sym_code;
  logic           cancel;
  logic [T_W-1:0] press_ticks;
  logic           key_down;
  logic [T_W-1:0] t;

  morse_key_timer #(
    .TICK_CYCLES     (TICK),
    .T_W             (T_W),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .button      (button),
    .sym_valid   (sym_valid),
    .sym_code    (sym_code),
    .cancel      (cancel),
    .press_ticks (press_ticks),
    .key_down    (key_down),
    .t           (t)
  );

  always #5 clk = ~clk;

  // kind: 0 dot, 1 dash, 2 interchar, 3 interword, 4 cancel; -1 fields are not checked
  typedef struct {
    int kind;
    int ticks;
    int delta;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  int   cyc_cnt = 0;
  int   last_strobe = 0;

  function automatic void check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endfunction

  function automatic void push_exp(int kind, int ticks, int delta);
    exp_t e;
    e.kind  = kind;
    e.ticks = ticks;
    e.delta = delta;
    exp_q.push_back(e);
  endfunction

  // Press of n cycles: ticks = floor(n/TICK) saturated; <=1 dot, <7 dash, else cancel.
  function automatic void model_press(int n);
    int tk;
    tk = n / TICK;
    if (tk > TMAX) tk = TMAX;
    if (tk <= 1)      push_exp(0, tk, -1);
    else if (tk < 7)  push_exp(1, tk, -1);
    else              push_exp(4, tk, -1);
  endfunction

  // Gap of g cycles: interchar 3 ticks after the press ends, interword 2 ticks later.
  function automatic void model_gap(int g);
    if (g / TICK >= 3) push_exp(2, -1, 3 * TICK);
    if (g / TICK >= 5) push_exp(3, -1, 2 * TICK);
  endfunction

  task automatic press(input int n);
    model_press(n);
    button = PRESSED;
    repeat (n) @(posedge clk);
    #1;
    button = RELEASED;
  endtask

  task automatic gap(input int g);
    model_gap(g);
    repeat (g) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int   kind;
    cyc_cnt++;
    if (mon_en && (sym_valid === 1'b1 || cancel === 1'b1)) begin
      check("single_strobe", int'(sym_valid & cancel), 0);
      kind = cancel ? 4 : int'(sym_code);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: got kind %0d at cycle %0d, expected no strobe", kind, cyc_cnt);
      end else begin
        e = exp_q.pop_front();
        check("symbol_kind", kind, e.kind);
        if (e.ticks >= 0) check("press_ticks", int'(press_ticks), e.ticks);
        if (e.delta >= 0) check("gap_timing", cyc_cnt - last_strobe, e.delta);
      end
      last_strobe = cyc_cnt;
    end
  end

  initial begin
    int lat;
    int n;
    int g;
    bit seen;

    reset  = 1'b1;
    button = PRESSED;
    repeat (5) @(posedge clk);
    #1;
    check("reset_sym_valid", int'(sym_valid), 0);
    check("reset_sym_code", int'(sym_code), 0);
    check("reset_cancel", int'(cancel), 0);
    check("reset_press_ticks", int'(press_ticks), 0);
    check("reset_key_down", int'(key_down), 0);
    check("reset_t", int'(t), 0);

    reset = 1'b0;
    lat = 0;
    while (key_down !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("key_down_latency", lat, 2 + DEB);

    // Key held through reset gives a 5-cycle debounced press once released.
    mon_en = 1'b1;
    model_press(5);
    button = RELEASED;
    gap(65);

    press(15);
    gap(65);
    press(25);
    gap(24);
    press(35);
    gap(64);
    press(75);
    gap(62);

    model_press(305);
    button = PRESSED;
    repeat (300) @(posedge clk);
    #1;
    check("t_saturated", int'(t), TMAX);
    repeat (5) @(posedge clk);
    #1;
    button = RELEASED;
    gap(66);

    button = PRESSED;
    repeat (2) @(posedge clk);
    #1;
    button = RELEASED;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (key_down) seen = 1'b1;
    end
    check("glitch_ignored", int'(seen), 0);

    for (int i = 0; i < 25; i++) begin
      n = 10 * int'($urandom_range(0, 20)) + int'($urandom_range(4, 8));
      g = 10 * int'($urandom_range(0, 6)) + int'($urandom_range(4, 8));
      press(n);
      gap(g);
    end
    gap(66);

    // Reset in the middle of a 25-cycle press must discard it.
    button = PRESSED;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    button = RELEASED;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("post_reset_press_ticks", int'(press_ticks), 0);
    check("post_reset_key_down", int'(key_down), 0);
    repeat (80) @(posedge clk);
    #1;

    lat = 0;
    while (exp_q.size() != 0 && lat < 200) begin
      @(posedge clk);
      lat++;
    end
    check("queue_drained", exp_q.size(), 0);
    repeat (100) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
